// File: rtl/pcw_sd_pkg.sv
// Shared types and sizes for the PCW virtual-disk sector controller.
// Imported by pcw_sd_sector_ram and pcw_sd_sector_ctrl.
package pcw_sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;
  localparam int LBA_W        = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } sd_state_e;

endpackage

// File: rtl/pcw_sd_sector_ram.sv
// True dual-port 512x8 sector buffer with a registered read on each port.
// Output registers clear on reset; the array itself is not reset.
module pcw_sd_sector_ram
  import pcw_sd_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SECTOR_AW-1:0] a_addr_i,
  input  logic [7:0]           a_din_i,
  input  logic                 a_we_i,
  output logic [7:0]           a_dout_o,
  input  logic [SECTOR_AW-1:0] b_addr_i,
  input  logic [7:0]           b_din_i,
  input  logic                 b_we_i,
  output logic [7:0]           b_dout_o
);

  logic [7:0] mem_q [SECTOR_BYTES];
  logic [7:0] a_q;
  logic [7:0] b_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) mem_q[a_addr_i] <= a_din_i;
    if (b_we_i) mem_q[b_addr_i] <= b_din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      a_q <= mem_q[a_addr_i];
      b_q <= mem_q[b_addr_i];
    end
  end

  assign a_dout_o = a_q;
  assign b_dout_o = b_q;

endmodule

// File: rtl/pcw_sd_sector_ctrl.sv
// Per-drive sector buffer and sd_rd/sd_wr initiator towards hps_io.
// Optional last-sector read cache: define SD_SECTOR_CACHE_EN.
module pcw_sd_sector_ctrl
  import pcw_sd_pkg::*;
#(
  parameter logic [31:0] ACK_TIMEOUT = 32'd16_000_000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 img_mounted,
  input  logic [63:0]          img_size,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [LBA_W-1:0]     req_lba,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [SECTOR_AW-1:0] fdc_addr,
  input  logic [7:0]           fdc_din,
  input  logic                 fdc_we,
  output logic [7:0]           fdc_dout,
  output logic [LBA_W-1:0]     sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic [SECTOR_AW-1:0] sd_buff_addr,
  input  logic [7:0]           sd_buff_dout,
  output logic [7:0]           sd_buff_din,
  input  logic                 sd_buff_wr
);

  sd_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             dir_q, dir_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [LBA_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [LBA_W-1:0] sec_q;
  logic             nz_q;
  logic             in_range;
  logic             hit;
  logic             abort;

  assign in_range = nz_q && (req_lba < sec_q);
  assign cnt_n    = cnt_q + 32'd1;

`ifdef SD_SECTOR_CACHE_EN
  logic             cv_q;
  logic [LBA_W-1:0] clba_q;

  assign hit = req_rd && cv_q && (clba_q == req_lba);

  // The buffer stays authoritative after FDC writes, so only
  // a new image or a failed request invalidates it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cv_q   <= 1'b0;
      clba_q <= '0;
    end else if (img_mounted || err_d) begin
      cv_q   <= 1'b0;
    end else if (state_q == REQ && sd_ack) begin
      cv_q   <= 1'b1;
      clba_q <= lba_q;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_rd | req_wr) begin
          if (!(req_rd ^ req_wr) || !in_range) begin
            err_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            lba_d  = req_lba;
            dir_d  = req_wr;
            if (hit) begin
              state_d = XFER;
            end else begin
              state_d = REQ;
              rd_d    = req_rd;
              wr_d    = req_wr;
              cnt_d   = 32'd1;
            end
          end
        end
      end
      REQ: begin
        if (img_mounted) begin
          abort = 1'b1;
        end else if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (ACK_TIMEOUT != 32'd0 &&
                     cnt_n >= ACK_TIMEOUT) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_n;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dir_q   <= 1'b0;
      lba_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sec_q <= '0;
      nz_q  <= 1'b0;
    end else if (img_mounted) begin
      sec_q <= img_size[40:9];
      nz_q  <= |img_size;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign sd_rd  = rd_q;
  assign sd_wr  = wr_q;
  assign sd_lba = lba_q;

  pcw_sd_sector_ram u_ram (
    .clk_i    (clk_sys),
    .rst_i    (reset),
    .a_addr_i (fdc_addr),
    .a_din_i  (fdc_din),
    .a_we_i   (fdc_we && !busy_q),
    .a_dout_o (fdc_dout),
    .b_addr_i (sd_buff_addr),
    .b_din_i  (sd_buff_dout),
    .b_we_i   (state_q == XFER && !dir_q && sd_buff_wr),
    .b_dout_o (sd_buff_din)
  );

endmodule

// File: tb/tb_pcw_sd_sector_ctrl.sv
// Scoreboard bench for pcw_sd_sector_ctrl with an HPS responder model.
// Cache expectations follow SD_SECTOR_CACHE_EN when it is defined.
module tb_pcw_sd_sector_ctrl;

  localparam int TMO = 100;
`ifdef SD_SECTOR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        req_rd, req_wr;
  logic [31:0] req_lba;
  logic        busy, done, err;
  logic [8:0]  fdc_addr;
  logic [7:0]  fdc_din;
  logic        fdc_we;
  logic [7:0]  fdc_dout;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;

  always #5 clk = ~clk;

  pcw_sd_sector_ctrl #(.ACK_TIMEOUT(32'(TMO))) dut (
    .clk_sys      (clk),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fdc_addr     (fdc_addr),
    .fdc_din      (fdc_din),
    .fdc_we       (fdc_we),
    .fdc_dout     (fdc_dout),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr)
  );

  typedef struct {
    logic [1:0] kind;
    longint     due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  longint      cyc = 0;

  logic [7:0]  mem_m [512];
  longint      size_m = 0;
  bit          cv_m = 1'b0;
  logic [31:0] clba_m = '0;
  int          exp_hps = 0;
  int          hps_reqs = 0;
  logic [31:0] exp_lba = '0;
  logic        exp_wr = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_dly = 10;
  bit          pat_mode = 1'b0;
  bit          skip_data = 1'b0;
  bit          hps_act = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor: every done/err pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'd0, done, err}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("outcome", {62'd0, done, err}, {62'd0, mon_e.kind});
        if (mon_e.due >= 0) chk("pulse_cycle", cyc, mon_e.due);
      end
    end
  end

  // HPS responder model.
  initial begin
    int bad;
    logic [7:0] d;
    sd_ack = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && !reset && (sd_rd || sd_wr)) begin
        hps_act = 1'b1;
        hps_reqs++;
        chk("hps_lba", sd_lba, exp_lba);
        chk("hps_dir", sd_wr, exp_wr);
        repeat (ack_dly) @(negedge clk);
        chk("req_held", sd_rd | sd_wr, 1);
        sd_ack = 1'b1;
        @(negedge clk);
        chk("req_drop", sd_rd | sd_wr, 0);
        if (exp_wr) begin
          bad = 0;
          sd_buff_addr = 9'd0;
          for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (sd_buff_din !== mem_m[i]) bad++;
            if (i < 511) sd_buff_addr = 9'(i + 1);
          end
          if (!skip_data) chk("hps_rd_data", bad, 0);
        end else begin
          for (int i = 0; i < 512; i++) begin
            d = pat_mode ? 8'(i) : 8'($urandom);
            sd_buff_addr = 9'(i);
            sd_buff_dout = d;
            sd_buff_wr = 1'b1;
            mem_m[i] = d;
            @(negedge clk);
          end
          sd_buff_wr = 1'b0;
        end
        sd_ack = 1'b0;
        hps_act = 1'b0;
      end
    end
  end

  // mode 0: normal, 1: ack timeout, 2: mount abort, 3: reset abort
  task automatic issue(input bit rd, input bit wr,
                       input logic [31:0] lba, input int mode);
    exp_t   e;
    longint sec;
    logic [31:0] sec32;
    bit     rej;
    sec   = size_m >> 9;
    sec32 = sec[31:0];
    rej   = 1'b0;
    e.kind = 2'b10;
    e.due  = -1;
    @(negedge clk);
    req_rd = rd;
    req_wr = wr;
    req_lba = lba;
    if (rd == wr || size_m == 0 || lba >= sec32) begin
      rej = 1'b1;
      e.kind = 2'b01;
      e.due = cyc + 1;
      cv_m = 1'b0;
    end else if (rd && CACHE && cv_m && clba_m == lba) begin
      e.due = cyc + 2;
    end else begin
      exp_lba = lba;
      exp_wr = wr;
      if (ack_en) exp_hps++;
      case (mode)
        0: begin cv_m = 1'b1; clba_m = lba; end
        1: begin e.kind = 2'b01; e.due = cyc + TMO; cv_m = 1'b0; end
        2: begin e.kind = 2'b01; cv_m = 1'b0; end
        default: cv_m = 1'b0;
      endcase
    end
    if (rej || mode != 3) sb.push_back(e);
    @(negedge clk);
    req_rd = 1'b0;
    req_wr = 1'b0;
    if (rej) chk("no_hps_req", {sd_rd, sd_wr}, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || hps_act) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", n < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic mount(input longint s);
    @(negedge clk);
    img_mounted = 1'b1;
    img_size = s;
    size_m = s;
    cv_m = 1'b0;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic fdc_wr(input int a, input logic [7:0] d);
    @(negedge clk);
    fdc_addr = 9'(a);
    fdc_din = d;
    fdc_we = 1'b1;
    mem_m[a] = d;
    @(negedge clk);
    fdc_we = 1'b0;
  endtask

  task automatic fdc_rd(input int a);
    @(negedge clk);
    fdc_addr = 9'(a);
    @(negedge clk);
    chk("fdc_dout", fdc_dout, mem_m[a]);
  endtask

  initial begin
    int n;
    int op;
    bit rd;
    logic [31:0] l;
    reset = 1'b1;
    img_mounted = 1'b0;
    img_size = '0;
    req_rd = 1'b0;
    req_wr = 1'b0;
    req_lba = '0;
    fdc_addr = '0;
    fdc_din = '0;
    fdc_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_fdc_dout", fdc_dout, 0);
    chk("rst_sd_buff_din", sd_buff_din, 0);
    reset = 1'b0;

    issue(1, 0, 5, 0);
    wait_idle();
    mount(737280);
    issue(1, 0, 1440, 0);
    wait_idle();
    issue(0, 1, 1440, 0);
    wait_idle();
    issue(1, 1, 3, 0);
    wait_idle();

    pat_mode = 1'b1;
    ack_dly = 10;
    issue(1, 0, 5, 0);
    wait_idle();
    pat_mode = 1'b0;
    fdc_rd(9'h101);
    chk("fdc_101", fdc_dout, 8'h01);

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      fdc_addr = 9'(i);
      fdc_din = 8'hA5;
      fdc_we = 1'b1;
      mem_m[i] = 8'hA5;
    end
    @(negedge clk);
    fdc_we = 1'b0;
    issue(0, 1, 7, 0);
    wait_idle();

    for (int k = 0; k < 10; k++) begin
      op = $urandom_range(0, 3);
      l = 32'($urandom_range(0, 1439));
      if (cv_m && $urandom_range(0, 1) == 1) l = clba_m;
      ack_dly = $urandom_range(0, 12);
      case (op)
        0: issue(1, 0, l, 0);
        1: begin
          repeat (4) fdc_wr($urandom_range(0, 511), 8'($urandom));
          issue(0, 1, l, 0);
        end
        2: begin
          rd = 1'($urandom_range(0, 1));
          issue(rd, !rd, 32'(1440 + $urandom_range(0, 100)), 0);
        end
        default: issue(1, 1, l, 0);
      endcase
      wait_idle();
      repeat (3) fdc_rd($urandom_range(0, 511));
    end

    mount(737280);
    ack_en = 1'b0;
    issue(1, 0, 3, 1);
    n = 0;
    while (sd_rd && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_sd_rd_cycles", n, TMO - 1);
    chk("tmo_busy", busy, 0);
    wait_idle();

    issue(0, 1, 9, 2);
    repeat (4) @(negedge clk);
    chk("abort_wr_held", sd_wr, 1);
    mount(737280);
    chk("abort_wr_drop", sd_wr, 0);
    chk("abort_busy", busy, 0);
    ack_en = 1'b1;
    wait_idle();

    ack_dly = 2;
    skip_data = 1'b1;
    issue(0, 1, 11, 3);
    n = 0;
    while (!sd_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_reached", sd_ack, 1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    size_m = 0;
    cv_m = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sd_wr", sd_wr, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sd_buff_din", sd_buff_din, 0);
    reset = 1'b0;
    wait_idle();
    skip_data = 1'b0;

    mount(737280);
    issue(1, 0, 5, 0);
    wait_idle();
    issue(1, 0, 5, 0);
    wait_idle();
    chk("hps_reqs_hit", hps_reqs, exp_hps);
    mount(737280);
    issue(1, 0, 5, 0);
    wait_idle();
    chk("hps_reqs_remount", hps_reqs, exp_hps);
    fdc_rd(0);
    fdc_rd(511);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
